// File: rtl/fixed_lane_pack_pkg.sv
// Shared constants, state encoding and helpers for the fixed-point lane packer.
package fixed_lane_pack_pkg;

    localparam int BUS_NUM          = 8;
    localparam int FIXED_DATA_WIDTH = 8;
    localparam int MEM_WIDTH        = BUS_NUM * FIXED_DATA_WIDTH;
    localparam int MEM_DEPTH        = 512;
    localparam int MEM_ADDR_WIDTH   = 9;
    localparam int CNT_WIDTH        = 4;
    // Residue (<BUS_NUM) plus one bus of lanes fits in 2*BUS_NUM slots.
    localparam int MRG_NUM          = 2 * BUS_NUM;
    localparam int MRG_CNT_WIDTH    = CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [BUS_NUM-1:0] i_vec);
        logic [CNT_WIDTH-1:0] v_cnt;
        v_cnt = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            v_cnt = v_cnt + CNT_WIDTH'(i_vec[i]);
        end
        return v_cnt;
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Combinational compaction: kept lanes are appended in lane order after the residue.
module lane_compactor
    import fixed_lane_pack_pkg::*;
(
    input  logic [MEM_WIDTH-1:0]                        in_data,
    input  logic [BUS_NUM-1:0]                          in_keep,
    input  logic [BUS_NUM-1:0][FIXED_DATA_WIDTH-1:0]    in_res,
    input  logic [CNT_WIDTH-1:0]                        in_res_cnt,
    output logic [MRG_NUM-1:0][FIXED_DATA_WIDTH-1:0]    out_merged,
    output logic [MRG_CNT_WIDTH-1:0]                    out_merged_cnt
);

    logic [MRG_CNT_WIDTH-1:0] w_pos;

    // Slots above the merged count stay zero, so the residue never carries stale bytes.
    always_comb begin
        out_merged = '0;
        w_pos      = {1'b0, in_res_cnt};
        for (int j = 0; j < BUS_NUM; j++) begin
            if (CNT_WIDTH'(j) < in_res_cnt) begin
                out_merged[j] = in_res[j];
            end
        end
        for (int i = 0; i < BUS_NUM; i++) begin
            if (in_keep[i]) begin
                out_merged[w_pos[MRG_CNT_WIDTH-2:0]] = in_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH];
                w_pos = w_pos + MRG_CNT_WIDTH'(1);
            end
        end
    end

    assign out_merged_cnt = {1'b0, in_res_cnt} + MRG_CNT_WIDTH'(popcount(in_keep));

endmodule

// File: rtl/fixed_lane_packer.sv
// Packs valid lanes into dense SRAM words from a base address; flush writes the partial tail.
// Optional RELU_PACK_ZERO_SKIP_EN: zero-valued elements are dropped as if their valid were low.
//   state | meaning
//   IDLE  | waiting for in_start; inputs ignored
//   RUN   | packing incoming lanes, writing full words
//   FLUSH | one cycle: write the partial residue word, then end the run
module fixed_lane_packer
    import fixed_lane_pack_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_start,
    input  logic [MEM_ADDR_WIDTH-1:0]   in_base_addr,
    input  logic [MEM_WIDTH-1:0]        in_fixed_data,
    input  logic [BUS_NUM-1:0]          in_fixed_data_vld,
    input  logic                        in_flush,
    output logic                        mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_waddr,
    output logic [MEM_WIDTH-1:0]        mem_wdata,
    output logic [BUS_NUM-1:0]          mem_wmask,
    output logic [MEM_ADDR_WIDTH:0]     out_word_cnt,
    output logic                        out_done,
    output logic                        out_overflow
);

    state_t r_state;
    state_t w_state_nxt;

    logic [BUS_NUM-1:0][FIXED_DATA_WIDTH-1:0] r_res;
    logic [CNT_WIDTH-1:0]                     r_res_cnt;
    logic [MEM_ADDR_WIDTH-1:0]                r_addr;

    logic [BUS_NUM-1:0]                       w_keep;
    logic [MRG_NUM-1:0][FIXED_DATA_WIDTH-1:0] w_merged;
    logic [MRG_CNT_WIDTH-1:0]                 w_merged_cnt;
    logic                                     w_word_full;
    logic                                     w_write;
    logic [MEM_WIDTH-1:0]                     w_wdata;
    logic [BUS_NUM-1:0]                       w_wmask;
    logic [BUS_NUM-1:0]                       w_part_mask;
    logic [MEM_WIDTH-1:0]                     w_part_data;

`ifdef RELU_PACK_ZERO_SKIP_EN
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            w_keep[i] = in_fixed_data_vld[i] &&
                        (in_fixed_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] != '0);
        end
    end
`else
    assign w_keep = in_fixed_data_vld;
`endif

    lane_compactor u_lane_compactor (
        .in_data        (in_fixed_data),
        .in_keep        (w_keep),
        .in_res         (r_res),
        .in_res_cnt     (r_res_cnt),
        .out_merged     (w_merged),
        .out_merged_cnt (w_merged_cnt)
    );

    assign w_word_full = (w_merged_cnt >= MRG_CNT_WIDTH'(BUS_NUM));

    always_comb begin
        w_part_mask = '0;
        w_part_data = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            w_part_mask[i] = (CNT_WIDTH'(i) < r_res_cnt);
            w_part_data[i*FIXED_DATA_WIDTH +: FIXED_DATA_WIDTH] =
                w_part_mask[i] ? r_res[i] : '0;
        end
    end

    always_comb begin
        w_write = 1'b0;
        w_wdata = w_merged[BUS_NUM-1:0];
        w_wmask = '1;
        if (r_state == RUN) begin
            w_write = w_word_full;
        end else if (r_state == FLUSH) begin
            w_write = (r_res_cnt != '0);
            w_wdata = w_part_data;
            w_wmask = w_part_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_start) w_state_nxt = RUN;
            RUN:     if (in_flush) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res     <= '0;
            r_res_cnt <= '0;
        end else if (r_state == RUN) begin
            if (w_word_full) begin
                r_res     <= w_merged[MRG_NUM-1:BUS_NUM];
                r_res_cnt <= CNT_WIDTH'(w_merged_cnt - MRG_CNT_WIDTH'(BUS_NUM));
            end else begin
                r_res     <= w_merged[BUS_NUM-1:0];
                r_res_cnt <= CNT_WIDTH'(w_merged_cnt);
            end
        end else if (r_state == FLUSH) begin
            r_res     <= '0;
            r_res_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            mem_wen      <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            out_word_cnt <= '0;
            out_done     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            mem_wen  <= w_write;
            out_done <= (r_state == FLUSH);
            if (r_state == IDLE && in_start) begin
                r_addr       <= in_base_addr;
                out_word_cnt <= '0;
                out_overflow <= 1'b0;
            end
            if (w_write) begin
                mem_waddr <= r_addr;
                mem_wdata <= w_wdata;
                mem_wmask <= w_wmask;
                r_addr    <= (r_addr == MEM_ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0
                                                                        : r_addr + MEM_ADDR_WIDTH'(1);
                // Saturate rather than wrap so a runaway run still reads as large.
                if (out_word_cnt != '1) begin
                    out_word_cnt <= out_word_cnt + (MEM_ADDR_WIDTH+1)'(1);
                end
                if (out_word_cnt >= (MEM_ADDR_WIDTH+1)'(MEM_DEPTH)) begin
                    out_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_lane_packer.sv
// Directed bench for fixed_lane_packer: queue-based element model checked every cycle.
module tb_fixed_lane_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start;
    logic [8:0]  in_base_addr;
    logic [63:0] in_fixed_data;
    logic [7:0]  in_fixed_data_vld;
    logic        in_flush;
    logic        mem_wen;
    logic [8:0]  mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [9:0]  out_word_cnt;
    logic        out_done;
    logic        out_overflow;

    fixed_lane_packer dut (
        .clk               (clk),
        .rst               (rst),
        .in_start          (in_start),
        .in_base_addr      (in_base_addr),
        .in_fixed_data     (in_fixed_data),
        .in_fixed_data_vld (in_fixed_data_vld),
        .in_flush          (in_flush),
        .mem_wen           (mem_wen),
        .mem_waddr         (mem_waddr),
        .mem_wdata         (mem_wdata),
        .mem_wmask         (mem_wmask),
        .out_word_cnt      (out_word_cnt),
        .out_done          (out_done),
        .out_overflow      (out_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a run is a stream of elements; every 8 queued elements make a word.
    int          m_mode;
    logic [7:0]  q[$];
    int          m_addr;
    int          m_cnt;
    bit          m_ovf;
    logic        e_wen;
    logic        e_done;
    logic [8:0]  e_waddr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wmask;

    logic [8:0]  log_addr[$];
    logic [63:0] log_data[$];
    logic [7:0]  log_mask[$];
    int          done_n;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_emit();
        int k;
        k = (q.size() > 8) ? 8 : q.size();
        e_wdata = '0;
        e_wmask = '0;
        for (int i = 0; i < k; i++) begin
            e_wdata[i*8 +: 8] = q.pop_front();
            e_wmask[i] = 1'b1;
        end
        e_wen   = 1'b1;
        e_waddr = m_addr[8:0];
        m_addr  = (m_addr + 1) % 512;
        m_cnt++;
        if (m_cnt > 512) m_ovf = 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; q.delete(); m_addr = 0; m_cnt = 0; m_ovf = 1'b0;
            e_wen = 1'b0; e_done = 1'b0; e_waddr = '0; e_wdata = '0; e_wmask = '0;
        end else begin
            e_wen  = 1'b0;
            e_done = 1'b0;
            case (m_mode)
                0: if (in_start) begin
                    m_addr = int'(in_base_addr); m_cnt = 0; m_ovf = 1'b0; m_mode = 1;
                end
                1: begin
                    for (int i = 0; i < 8; i++) begin
`ifdef RELU_PACK_ZERO_SKIP_EN
                        if (in_fixed_data_vld[i] && in_fixed_data[i*8 +: 8] != 8'h00)
`else
                        if (in_fixed_data_vld[i])
`endif
                            q.push_back(in_fixed_data[i*8 +: 8]);
                    end
                    if (q.size() >= 8) m_emit();
                    if (in_flush) m_mode = 2;
                end
                default: begin
                    if (q.size() > 0) m_emit();
                    e_done = 1'b1;
                    q.delete();
                    m_mode = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("wen", mem_wen, e_wen);
        check("done", out_done, e_done);
        check("word_cnt", out_word_cnt, (m_cnt > 1023) ? 1023 : m_cnt);
        check("overflow", out_overflow, m_ovf);
        if (e_wen === 1'b1) begin
            check("waddr", mem_waddr, e_waddr);
            check("wdata", mem_wdata, e_wdata);
            check("wmask", mem_wmask, e_wmask);
        end
        if (mem_wen === 1'b1) begin
            log_addr.push_back(mem_waddr);
            log_data.push_back(mem_wdata);
            log_mask.push_back(mem_wmask);
        end
        if (out_done === 1'b1) done_n++;
    end

    task automatic cyc(input bit s, input logic [8:0] b, input logic [63:0] d,
                       input logic [7:0] v, input bit f);
        in_start = s; in_base_addr = b; in_fixed_data = d; in_fixed_data_vld = v; in_flush = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_mask.delete(); done_n = 0;
    endtask

    initial begin
        rst = 1'b1; in_start = 1'b0; in_base_addr = '0; in_fixed_data = '0;
        in_fixed_data_vld = '0; in_flush = 1'b0; done_n = 0;
        repeat (2) @(negedge clk);
        check("rst_wen", mem_wen, 1'b0);
        check("rst_cnt", out_word_cnt, 10'd0);
        check("rst_ovf", out_overflow, 1'b0);
        rst = 1'b0;
        idle(2);

        // Three full words then an empty flush.
        clear_log();
        cyc(1'b1, 9'h000, 64'h0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 9'h0, 64'h0706050403020100, 8'hFF, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s1_nwr", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_addr.size()) begin
                check("s1_addr", log_addr[i], i);
                check("s1_data", log_data[i], 64'h0706050403020100);
                check("s1_mask", log_mask[i], 8'hFF);
            end
        end
        check("s1_done", done_n, 1);
        check("s1_cnt", out_word_cnt, 10'd3);

        // Sparse lanes; start+flush together in IDLE starts only; start in RUN ignored.
        clear_log();
        cyc(1'b1, 9'h010, 64'h0, 8'h00, 1'b1);
        cyc(1'b0, 9'h0, 64'h0000000000_33EE11, 8'h05, 1'b0);
        cyc(1'b0, 9'h0, 64'h0000000000_33EE11, 8'h05, 1'b0);
        cyc(1'b1, 9'h100, 64'h0, 8'h00, 1'b0);
        cyc(1'b0, 9'h0, 64'h0000000000_33EE11, 8'h05, 1'b0);
        cyc(1'b0, 9'h0, 64'h0000000000_33EE11, 8'h05, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s2_nwr", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("s2_addr", log_addr[0], 9'h010);
            check("s2_data", log_data[0], 64'h3311331133113311);
            check("s2_mask", log_mask[0], 8'hFF);
        end

        // Five elements then flush: partial word.
        clear_log();
        cyc(1'b1, 9'h020, 64'h0, 8'h00, 1'b0);
        cyc(1'b0, 9'h0, 64'hEEEEEEA5A4A3A2A1, 8'h1F, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s3_nwr", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("s3_addr", log_addr[0], 9'h020);
            check("s3_data", log_data[0], 64'h000000A5A4A3A2A1);
            check("s3_mask", log_mask[0], 8'h1F);
        end
        check("s3_done", done_n, 1);

        // Residue 6, flush cycle brings 5 more: full word then 3-element tail.
        clear_log();
        cyc(1'b1, 9'h030, 64'h0, 8'h00, 1'b0);
        cyc(1'b0, 9'h0, 64'hEEEEB5B4B3B2B1B0, 8'h3F, 1'b0);
        cyc(1'b0, 9'h0, 64'hEEEEEEC4C3C2C1C0, 8'h1F, 1'b1);
        idle(3);
        check("s4_nwr", log_addr.size(), 2);
        if (log_addr.size() > 1) begin
            check("s4_data0", log_data[0], 64'hC1C0B5B4B3B2B1B0);
            check("s4_mask0", log_mask[0], 8'hFF);
            check("s4_addr1", log_addr[1], 9'h031);
            check("s4_data1", log_data[1], 64'h0000000000C4C3C2);
            check("s4_mask1", log_mask[1], 8'h07);
        end

        // Address wrap at the top of memory.
        clear_log();
        cyc(1'b1, 9'h1FE, 64'h0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 9'h0, 64'h1122334455667788, 8'hFF, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s5_nwr", log_addr.size(), 3);
        if (log_addr.size() > 2) begin
            check("s5_addr0", log_addr[0], 9'h1FE);
            check("s5_addr1", log_addr[1], 9'h1FF);
            check("s5_addr2", log_addr[2], 9'h000);
        end

        // Reset mid-run with residue 4, then a clean run elsewhere.
        clear_log();
        cyc(1'b1, 9'h050, 64'h0, 8'h00, 1'b0);
        cyc(1'b0, 9'h0, 64'h00000000F3F2F1F0, 8'h0F, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        check("s6_nwr_after_rst", log_addr.size(), 0);
        cyc(1'b1, 9'h040, 64'h0, 8'h00, 1'b0);
        cyc(1'b0, 9'h0, 64'hD7D6D5D4D3D2D1D0, 8'hFF, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s6_nwr", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("s6_addr", log_addr[0], 9'h040);
            check("s6_data", log_data[0], 64'hD7D6D5D4D3D2D1D0);
        end

        // 513 words from base 0: overflow sets, sticks, clears on the next start.
        clear_log();
        cyc(1'b1, 9'h000, 64'h0, 8'h00, 1'b0);
        for (int i = 0; i < 513; i++) cyc(1'b0, 9'h0, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);
        check("s7_ovf", out_overflow, 1'b1);
        check("s7_cnt", out_word_cnt, 10'd513);
        check("s7_nwr", log_addr.size(), 513);
        if (log_addr.size() > 512) check("s7_addr_wrap", log_addr[512], 9'h000);
        idle(5);
        check("s7_ovf_sticky", out_overflow, 1'b1);
        cyc(1'b1, 9'h000, 64'h0, 8'h00, 1'b0);
        check("s7_ovf_clr", out_overflow, 1'b0);
        check("s7_cnt_clr", out_word_cnt, 10'd0);
        cyc(1'b0, 9'h0, 64'h0, 8'h00, 1'b1);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
